// File: rtl/seven_segment_arbiter.sv
// Round-robin owner selection for a shared seven-segment display driver.
// Each owner keeps the display for a minimum dwell while others are waiting.
// The owner can always give the display up early by dropping its request.
module seven_segment_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 16,
  parameter int DWELL_CYCLES = 62_500_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           disp_valid,
  output logic [DATA_BITS-1:0]           disp_data
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [0:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [OW-1:0] rr_ptr, nxt_ptr;
  logic [OW-1:0] nxt_owner;
  logic          nxt_valid;
  logic          found;
  logic [OW-1:0] win;
  int            idx;

  // Round-robin search from rr_ptr+1, wrapping; rr_ptr itself is checked last.
  // While showing, rr_ptr equals the owner, so a dropped owner is excluded
  // automatically and a still-requesting owner sits at lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // Next owner, dwell counter and scheduler state.
  always_comb begin
    nxt_state = state;
    nxt_valid = disp_valid;
    nxt_owner = owner;
    nxt_cnt   = cnt;
    nxt_ptr   = rr_ptr;
    case (state)
      IDLE: begin
        nxt_valid = 1'b0;
        nxt_owner = '0;
        nxt_cnt   = '0;
        if (found) begin
          nxt_state = SHOW;
          nxt_valid = 1'b1;
          nxt_owner = win;
          nxt_cnt   = RELOAD;
          nxt_ptr   = win;
        end
      end
      SHOW: begin
        if (!req[owner]) begin
          // Owner let go: hand over immediately, or go idle if nobody waits.
          if (found) begin
            nxt_owner = win;
            nxt_cnt   = RELOAD;
            nxt_ptr   = win;
          end else begin
            nxt_state = IDLE;
            nxt_valid = 1'b0;
            nxt_owner = '0;
            nxt_cnt   = '0;
          end
        end else if (cnt == '0) begin
          // Dwell expired; the owner is still requesting so a winner always exists.
          nxt_owner = win;
          nxt_cnt   = RELOAD;
          nxt_ptr   = win;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_valid = 1'b0;
        nxt_owner = '0;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Register scheduler state and all outputs; data follows the next owner live.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= OW'(NUM_REQ - 1);
      owner      <= '0;
      grant      <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      rr_ptr     <= nxt_ptr;
      owner      <= nxt_owner;
      disp_valid <= nxt_valid;
      grant      <= nxt_valid ? (NUM_REQ'(1) << nxt_owner) : '0;
      disp_data  <= nxt_valid ? req_data[nxt_owner*DATA_BITS +: DATA_BITS] : '0;
    end
  end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Scoreboard bench for seven_segment_arbiter: directed scenarios then random traffic.
// The reference model tracks how long the owner has held the display (counting up)
// and picks winners by scanning requesters after the last owner.
module tb_seven_segment_arbiter;
  localparam int N  = 4;
  localparam int DB = 16;
  localparam int DW = 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DB-1:0]   req_data;
  logic [N-1:0]      grant;
  logic [1:0]        owner;
  logic              disp_valid;
  logic [DB-1:0]     disp_data;

  seven_segment_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .owner(owner), .disp_valid(disp_valid), .disp_data(disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic          valid;
    logic [DB-1:0] data;
    string         tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  string phase = "init";

  // model state
  int m_own  = -1;
  int m_held = 0;
  int m_last = N - 1;

  function automatic int pick(input logic [N-1:0] rq, input int last);
    for (int k = 1; k <= N; k++) begin
      if (rq[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void model(input logic r, input logic [N-1:0] rq, input logic [N*DB-1:0] d);
    int w;
    exp_t e;
    if (r) begin
      m_own = -1; m_held = 0; m_last = N - 1;
    end else if (m_own < 0) begin
      w = pick(rq, m_last);
      if (w >= 0) begin m_own = w; m_held = 1; m_last = w; end
    end else if (!rq[m_own]) begin
      w = pick(rq, m_last);
      if (w >= 0) begin m_own = w; m_held = 1; m_last = w; end
      else m_own = -1;
    end else if (m_held == DW) begin
      w = pick(rq, m_last);
      m_own = w; m_held = 1; m_last = w;
    end else begin
      m_held++;
    end
    e.valid = (m_own >= 0);
    e.grant = e.valid ? N'(1) << m_own : '0;
    e.owner = e.valid ? 2'(m_own) : 2'd0;
    e.data  = e.valid ? d[m_own*DB +: DB] : '0;
    e.tag   = phase;
    q.push_back(e);
  endfunction

  // one clock: drive inputs, record the expected response to this edge
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*DB-1:0] d);
    rst = r; req = rq; req_data = d;
    model(r, rq, d);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input logic [N-1:0] rq, input logic [N*DB-1:0] d);
    for (int i = 0; i < n; i++) step(1'b0, rq, d);
  endtask

  // monitor: outputs are presented every cycle, compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (grant !== e.grant || owner !== e.owner || disp_valid !== e.valid || disp_data !== e.data) begin
        fails++;
        $display("FAIL %s t=%0t: got grant=%b owner=%0d valid=%b data=%h, want grant=%b owner=%0d valid=%b data=%h",
                 e.tag, $time, grant, owner, disp_valid, disp_data, e.grant, e.owner, e.valid, e.data);
      end
    end
  end

  logic [N*DB-1:0] d;

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    d = {16'hDDDD, 16'h1234, 16'hBBBB, 16'hAAAA};

    phase = "reset";
    step(1'b1, 4'b1111, d);
    step(1'b1, 4'b1111, d);

    phase = "single_owner_expiries";
    hold(30, 4'b0100, d);
    phase = "live_data_change";
    d[2*DB +: DB] = 16'h5678;
    hold(3, 4'b0100, d);

    phase = "idle_gap";
    hold(2, 4'b0000, d);
    phase = "two_way_contention";
    hold(20, 4'b1001, d);

    phase = "owner_drop_midwell";
    hold(2, 4'b0000, d);
    hold(3, 4'b0110, d);
    hold(10, 4'b0100, d);

    phase = "all_drop";
    hold(2, 4'b0000, d);
    phase = "rerequest_3";
    hold(4, 4'b1000, d);

    phase = "reset_mid_show";
    hold(2, 4'b0000, d);
    hold(4, 4'b0100, d);
    step(1'b1, 4'b0100, d);
    phase = "rr_after_reset";
    hold(36, 4'b1111, d);

    phase = "random";
    req = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] rq;
      logic r;
      rq = req;
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) d[b*DB +: DB] = DB'($urandom);
      r = ($urandom_range(299) == 0);
      step(r, rq, d);
    end

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
